// File: rtl/bus_dma_pkg.sv
// rtl/bus_dma_pkg.sv - register map, bit positions and FSM states for the word-copy DMA
package bus_dma_pkg;

    localparam logic [4:0] REG_SRC    = 5'h00;
    localparam logic [4:0] REG_DST    = 5'h04;
    localparam logic [4:0] REG_LEN    = 5'h08;
    localparam logic [4:0] REG_CTRL   = 5'h0C;
    localparam logic [4:0] REG_STATUS = 5'h10;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam int STATUS_BUSY = 0;
    localparam int STATUS_DONE = 1;
    localparam int STATUS_ERR  = 2;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        ABORT
    } dma_state_e;

endpackage

// File: rtl/bus_dma_regs.sv
// rtl/bus_dma_regs.sv - device-port register file, sticky flags and interrupt register
module bus_dma_regs
    import bus_dma_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32,
    parameter int LenWidth     = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    dev_req_i,
    input  logic                    dev_we_i,
    input  logic [2:0]              dev_word_i,
    input  logic [DataWidth-1:0]    dev_wdata_i,
    output logic                    dev_rvalid_o,
    output logic [DataWidth-1:0]    dev_rdata_o,
    output logic                    dev_err_o,
    input  logic                    busy_i,
    input  logic                    done_set_i,
    input  logic                    err_set_i,
    output logic [AddressWidth-1:0] src_o,
    output logic [AddressWidth-1:0] dst_o,
    output logic [LenWidth-1:0]     len_o,
    output logic                    start_o,
    output logic                    irq_o
);
    logic [4:0]           offset;
    logic                 mapped, wr_en, rd_en, w1c, restart;
    logic                 irq_en, done_q, err_q;
    logic [DataWidth-1:0] rdata;

    assign offset  = {dev_word_i, 2'b00};
    assign mapped  = (dev_word_i < 3'd5);
    assign wr_en   = dev_req_i & dev_we_i & mapped;
    assign rd_en   = dev_req_i & ~dev_we_i & mapped;
    assign w1c     = wr_en & (offset == REG_STATUS);
    assign start_o = wr_en & (offset == REG_CTRL) & dev_wdata_i[CTRL_START] & ~busy_i;
    // A start that launches a transfer wipes the previous outcome
    assign restart = start_o & (len_o != '0);

    always_comb begin
        rdata = '0;
        case (offset)
            REG_SRC:    rdata = DataWidth'(src_o);
            REG_DST:    rdata = DataWidth'(dst_o);
            REG_LEN:    rdata = DataWidth'(len_o);
            REG_CTRL:   rdata[CTRL_IRQ_EN] = irq_en;
            REG_STATUS: begin
                rdata[STATUS_BUSY] = busy_i;
                rdata[STATUS_DONE] = done_q;
                rdata[STATUS_ERR]  = err_q;
            end
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dev_rvalid_o <= 1'b0;
            dev_rdata_o  <= '0;
            dev_err_o    <= 1'b0;
            src_o        <= '0;
            dst_o        <= '0;
            len_o        <= '0;
            irq_en       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            irq_o        <= 1'b0;
        end else begin
            dev_rvalid_o <= dev_req_i;
            dev_err_o    <= dev_req_i & ~mapped;
            dev_rdata_o  <= rd_en ? rdata : '0;
            if (wr_en && !busy_i) begin
                if (offset == REG_SRC) src_o <= {dev_wdata_i[AddressWidth-1:2], 2'b00};
                if (offset == REG_DST) dst_o <= {dev_wdata_i[AddressWidth-1:2], 2'b00};
                if (offset == REG_LEN) len_o <= dev_wdata_i[LenWidth-1:0];
            end
            if (wr_en && offset == REG_CTRL) irq_en <= dev_wdata_i[CTRL_IRQ_EN];
            // Hardware set has priority over software clear
            done_q <= done_set_i | (done_q & ~(w1c & dev_wdata_i[STATUS_DONE]) & ~restart);
            err_q  <= err_set_i  | (err_q  & ~(w1c & dev_wdata_i[STATUS_ERR])  & ~restart);
            irq_o  <= irq_en & (done_q | err_q);
        end
    end

endmodule

// File: rtl/bus_dma_host.sv
// rtl/bus_dma_host.sv - single-channel word-copy DMA initiator with one outstanding bus access
module bus_dma_host
    import bus_dma_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32,
    parameter int LenWidth     = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    dev_req_i,
    input  logic                    dev_we_i,
    input  logic [3:0]              dev_be_i,
    input  logic [AddressWidth-1:0] dev_addr_i,
    input  logic [DataWidth-1:0]    dev_wdata_i,
    output logic                    dev_rvalid_o,
    output logic [DataWidth-1:0]    dev_rdata_o,
    output logic                    dev_err_o,
    output logic                    host_req_o,
    input  logic                    host_gnt_i,
    output logic [AddressWidth-1:0] host_addr_o,
    output logic                    host_we_o,
    output logic [3:0]              host_be_o,
    output logic [DataWidth-1:0]    host_wdata_o,
    input  logic                    host_rvalid_i,
    input  logic [DataWidth-1:0]    host_rdata_i,
    input  logic                    host_err_i,
    output logic                    irq_o
);
    logic [AddressWidth-1:0] src, dst, rd_ptr, wr_ptr;
    logic [LenWidth-1:0]     len, remaining;
    logic                    start, busy, done_set, err_set;
    logic                    unused_bits;
    dma_state_e              state;

    assign unused_bits = ^{dev_be_i, dev_addr_i[AddressWidth-1:5], dev_addr_i[1:0]};
    assign busy        = (state != IDLE);
    assign host_be_o   = 4'hF;
    assign done_set    = (start && len == '0) ||
                         (state == WR_WAIT && host_rvalid_i && !host_err_i &&
                          remaining == LenWidth'(1));
    assign err_set     = (state == ABORT);

    bus_dma_regs #(
        .DataWidth   (DataWidth),
        .AddressWidth(AddressWidth),
        .LenWidth    (LenWidth)
    ) u_regs (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .dev_req_i   (dev_req_i),
        .dev_we_i    (dev_we_i),
        .dev_word_i  (dev_addr_i[4:2]),
        .dev_wdata_i (dev_wdata_i),
        .dev_rvalid_o(dev_rvalid_o),
        .dev_rdata_o (dev_rdata_o),
        .dev_err_o   (dev_err_o),
        .busy_i      (busy),
        .done_set_i  (done_set),
        .err_set_i   (err_set),
        .src_o       (src),
        .dst_o       (dst),
        .len_o       (len),
        .start_o     (start),
        .irq_o       (irq_o)
    );

    // host_wdata_o doubles as the one-word copy buffer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            remaining    <= '0;
            host_req_o   <= 1'b0;
            host_we_o    <= 1'b0;
            host_addr_o  <= '0;
            host_wdata_o <= '0;
        end else begin
            case (state)
                IDLE: if (start && len != '0) begin
                    rd_ptr      <= src;
                    wr_ptr      <= dst;
                    remaining   <= len;
                    host_req_o  <= 1'b1;
                    host_we_o   <= 1'b0;
                    host_addr_o <= src;
                    state       <= RD_REQ;
                end
                RD_REQ: if (host_gnt_i) begin
                    host_req_o <= 1'b0;
                    state      <= RD_WAIT;
                end
                RD_WAIT: if (host_rvalid_i) begin
                    if (host_err_i) begin
                        state <= ABORT;
                    end else begin
                        host_wdata_o <= host_rdata_i;
                        rd_ptr       <= rd_ptr + AddressWidth'(4);
                        host_req_o   <= 1'b1;
                        host_we_o    <= 1'b1;
                        host_addr_o  <= wr_ptr;
                        state        <= WR_REQ;
                    end
                end
                WR_REQ: if (host_gnt_i) begin
                    host_req_o <= 1'b0;
                    host_we_o  <= 1'b0;
                    state      <= WR_WAIT;
                end
                WR_WAIT: if (host_rvalid_i) begin
                    if (host_err_i) begin
                        state <= ABORT;
                    end else begin
                        wr_ptr    <= wr_ptr + AddressWidth'(4);
                        remaining <= remaining - LenWidth'(1);
                        if (remaining == LenWidth'(1)) begin
                            state <= IDLE;
                        end else begin
                            host_req_o  <= 1'b1;
                            host_addr_o <= rd_ptr;
                            state       <= RD_REQ;
                        end
                    end
                end
                ABORT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    rvalid_only_when_waiting: assert property (@(posedge clk_i) disable iff (!rst_ni)
        host_rvalid_i |-> (state != RD_REQ && state != WR_REQ));

    req_held_until_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (host_req_o && !host_gnt_i) |=> host_req_o);

endmodule

// File: tb/tb_bus_dma_host.sv
// tb/tb_bus_dma_host.sv - randomized copy transfers checked against a word-level memory model
module tb_bus_dma_host;

    localparam logic [31:0] A_SRC = 32'h00, A_DST = 32'h04, A_LEN = 32'h08;
    localparam logic [31:0] A_CTRL = 32'h0C, A_STATUS = 32'h10;

    logic        clk = 1'b0, rst_ni = 1'b0;
    logic        dev_req_i = 1'b0, dev_we_i = 1'b0;
    logic [3:0]  dev_be_i = 4'hF;
    logic [31:0] dev_addr_i = '0, dev_wdata_i = '0;
    logic        dev_rvalid_o, dev_err_o;
    logic [31:0] dev_rdata_o;
    logic        host_req_o, host_we_o;
    logic        host_gnt_i = 1'b0, host_rvalid_i = 1'b0, host_err_i = 1'b0;
    logic [31:0] host_addr_o, host_wdata_o, host_rdata_i = '0;
    logic [3:0]  host_be_o;
    logic        irq_o;

    always #5 clk = ~clk;

    bus_dma_host dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .dev_req_i(dev_req_i), .dev_we_i(dev_we_i), .dev_be_i(dev_be_i),
        .dev_addr_i(dev_addr_i), .dev_wdata_i(dev_wdata_i),
        .dev_rvalid_o(dev_rvalid_o), .dev_rdata_o(dev_rdata_o), .dev_err_o(dev_err_o),
        .host_req_o(host_req_o), .host_gnt_i(host_gnt_i), .host_addr_o(host_addr_o),
        .host_we_o(host_we_o), .host_be_o(host_be_o), .host_wdata_o(host_wdata_o),
        .host_rvalid_i(host_rvalid_i), .host_rdata_i(host_rdata_i), .host_err_i(host_err_i),
        .irq_o(irq_o)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    int   vectors = 0, miscompares = 0;
    txn_t exp_q[$];
    txn_t log_q[$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] mm  [logic [31:0]];
    int   rd_err_idx = -1, wr_err_idx = -1, n_rd = 0, n_wr = 0;
    int   force_gnt_dly = -1, force_rsp_dly = -1;
    bit   slave_pend = 0, exp_err_g = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction

    // Bus responder: random grant and response latency, error injection by word index
    initial begin : bus_slave
        bit in_req = 0; bit p_we = 0, p_err = 0;
        int dly = 0, gdly = 0;
        logic [31:0] p_addr = '0, p_data = '0;
        forever begin
            @(negedge clk);
            host_gnt_i = 0; host_rvalid_i = 0; host_err_i = 0; host_rdata_i = '0;
            if (!rst_ni) begin
                slave_pend = 0; in_req = 0;
            end else if (slave_pend) begin
                if (dly == 0) begin
                    host_rvalid_i = 1; host_err_i = p_err;
                    if (!p_we) host_rdata_i = mem_rd(p_addr);
                    else if (!p_err) mem[p_addr] = p_data;
                    slave_pend = 0;
                end else dly--;
            end else if (host_req_o) begin
                if (!in_req) begin
                    in_req = 1;
                    gdly = (force_gnt_dly >= 0) ? force_gnt_dly : int'($urandom_range(0, 2));
                    force_gnt_dly = -1;
                end
                if (gdly == 0) begin
                    host_gnt_i = 1; in_req = 0; slave_pend = 1;
                    p_addr = host_addr_o; p_we = host_we_o; p_data = host_wdata_o;
                    if (p_we) begin p_err = (n_wr == wr_err_idx); n_wr++; end
                    else      begin p_err = (n_rd == rd_err_idx); n_rd++; end
                    dly = (force_rsp_dly >= 0) ? force_rsp_dly : int'($urandom_range(0, 2));
                end else gdly--;
            end
        end
    end

    // Compare process: request stability and every granted transaction against the model
    initial begin : compare
        bit held = 0;
        txn_t h = '0, e;
        forever begin
            @(negedge clk); #2;
            if (!rst_ni || !host_req_o) begin
                held = 0;
            end else begin
                if (held) begin
                    check("req_addr_stable", host_addr_o, h.addr);
                    check("req_we_stable", host_we_o, h.we);
                    if (h.we) check("req_wdata_stable", host_wdata_o, h.data);
                end else begin
                    h = txn_t'{we: host_we_o, addr: host_addr_o, data: host_wdata_o};
                    held = 1;
                end
                if (host_gnt_i) begin
                    held = 0;
                    log_q.push_back(txn_t'{we: host_we_o, addr: host_addr_o, data: host_wdata_o});
                    if (exp_q.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL txn_unexpected: got addr 0x%08h we %0d, expected no transaction",
                                 host_addr_o, host_we_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("txn_we", host_we_o, e.we);
                        check("txn_addr", host_addr_o, e.addr);
                        if (e.we) check("txn_wdata", host_wdata_o, e.data);
                    end
                end
            end
        end
    end

    // Word-level model: what a copy of len words must do to the bus and to memory
    task automatic model_transfer(input logic [31:0] src, dst, input int len, rerr, werr);
        exp_err_g = 0;
        for (int i = 0; i < len; i++) begin
            logic [31:0] ra, wa, d;
            ra = src + 32'(4 * i);
            wa = dst + 32'(4 * i);
            d  = mm.exists(ra) ? mm[ra] : init_word(ra);
            exp_q.push_back(txn_t'{we: 1'b0, addr: ra, data: 32'h0});
            if (i == rerr) begin exp_err_g = 1; return; end
            exp_q.push_back(txn_t'{we: 1'b1, addr: wa, data: d});
            if (i == werr) begin exp_err_g = 1; return; end
            mm[wa] = d;
        end
    endtask

    task automatic dev_access(input bit we, input logic [31:0] addr, wdata,
                              output logic [31:0] rdata, output logic err);
        dev_req_i = 1; dev_we_i = we; dev_addr_i = addr; dev_wdata_i = wdata;
        @(negedge clk);
        dev_req_i = 0; dev_we_i = 0;
        check("dev_rvalid", dev_rvalid_o, 1);
        rdata = dev_rdata_o; err = dev_err_o;
    endtask

    task automatic reg_wr(input logic [31:0] addr, data);
        logic [31:0] rd; logic er;
        dev_access(1'b1, addr, data, rd, er);
        check("wr_rdata", rd, 0);
        check("wr_err", er, 0);
    endtask

    task automatic reg_rd(input logic [31:0] addr, output logic [31:0] rd);
        logic er;
        dev_access(1'b0, addr, 32'h0, rd, er);
        check("rd_err", er, 0);
    endtask

    task automatic start_transfer(input logic [31:0] src, dst, input int len, input bit irq_en,
                                  input int rerr, werr);
        log_q.delete(); n_rd = 0; n_wr = 0; rd_err_idx = rerr; wr_err_idx = werr;
        reg_wr(A_SRC, src);
        reg_wr(A_DST, dst);
        reg_wr(A_LEN, 32'(len));
        model_transfer(src & ~32'h3, dst & ~32'h3, len, rerr, werr);
        reg_wr(A_CTRL, {30'b0, irq_en, 1'b1});
    endtask

    task automatic finish_transfer(input string tag, input int len, input bit irq_en);
        logic [31:0] rd;
        int cyc = 0;
        while ((exp_q.size() != 0 || slave_pend) && cyc < 2000) begin
            @(negedge clk); cyc++;
        end
        if (cyc >= 2000) begin
            vectors++; miscompares++;
            $display("FAIL %s_timeout: %0d transactions outstanding, expected 0", tag, exp_q.size());
            exp_q.delete();
        end
        if (len != 0) repeat (2) @(negedge clk);
        reg_rd(A_STATUS, rd);
        check({tag, "_status"}, rd, (len != 0 && exp_err_g) ? 32'h4 : 32'h2);
        check({tag, "_irq"}, irq_o, irq_en);
        check({tag, "_mem_size"}, mem.size(), mm.size());
        foreach (mm[a]) check({tag, "_mem"}, mem.exists(a) ? mem[a] : 32'hxxxxxxxx, mm[a]);
        reg_wr(A_STATUS, 32'h6);
        @(negedge clk);
        check({tag, "_irq_cleared"}, irq_o, 0);
        reg_rd(A_STATUS, rd);
        check({tag, "_status_cleared"}, rd, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_host_req"}, host_req_o, 0);
        check({tag, "_host_we"}, host_we_o, 0);
        check({tag, "_host_addr"}, host_addr_o, 0);
        check({tag, "_host_wdata"}, host_wdata_o, 0);
        check({tag, "_host_be"}, host_be_o, 4'hF);
        check({tag, "_irq"}, irq_o, 0);
        check({tag, "_dev_rvalid"}, dev_rvalid_o, 0);
        check({tag, "_dev_rdata"}, dev_rdata_o, 0);
        check({tag, "_dev_err"}, dev_err_o, 0);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] rd, saved;
        logic er;
        int cyc, len, rerr, werr, kind;
        logic [31:0] src, dst;
        bit irq_en;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_ni = 1;
        @(negedge clk);
        reg_rd(A_SRC, rd);    check("reset_src", rd, 0);
        reg_rd(A_DST, rd);    check("reset_dst", rd, 0);
        reg_rd(A_LEN, rd);    check("reset_len", rd, 0);
        reg_rd(A_CTRL, rd);   check("reset_ctrl", rd, 0);
        reg_rd(A_STATUS, rd); check("reset_status", rd, 0);

        start_transfer(32'h0010_0000, 32'h0010_0100, 4, 1, -1, -1);
        finish_transfer("copy4", 4, 1);
        check("copy4_txn_count", log_q.size(), 8);
        check("copy4_first_addr", log_q[0].addr, 32'h0010_0000);
        check("copy4_second_addr", log_q[1].addr, 32'h0010_0100);
        check("copy4_last_addr", log_q[7].addr, 32'h0010_010C);
        check("copy4_last_we", log_q[7].we, 1);
        check("copy4_last_word", mem[32'h0010_010C], init_word(32'h0010_000C));

        start_transfer(32'h0000_2000, 32'h0000_2400, 0, 1, -1, -1);
        finish_transfer("len0", 0, 1);
        check("len0_txn_count", log_q.size(), 0);

        force_gnt_dly = 3;
        start_transfer(32'h0000_3000, 32'h0000_3800, 3, 0, -1, -1);
        finish_transfer("slow_gnt", 3, 0);
        check("slow_gnt_txn_count", log_q.size(), 6);

        start_transfer(32'h0000_4000, 32'h0000_5000, 3, 1, 1, -1);
        finish_transfer("rd_err", 3, 1);
        check("rd_err_writes", n_wr, 1);

        start_transfer(32'h0000_6000, 32'h0000_6100, 2, 1, -1, 1);
        finish_transfer("wr_err", 2, 1);

        start_transfer(32'h0000_8000, 32'h0000_8004, 3, 0, -1, -1);
        finish_transfer("overlap", 3, 0);

        start_transfer(32'hFFFF_FFF8, 32'h0000_9000, 4, 1, -1, -1);
        finish_transfer("wrap", 4, 1);

        start_transfer(32'h0000_A000, 32'h0000_B000, 8, 1, -1, -1);
        reg_rd(A_STATUS, rd);            check("busy_status", rd, 32'h1);
        reg_wr(A_SRC, 32'hDEAD_0000);
        reg_rd(A_SRC, rd);               check("busy_src_kept", rd, 32'h0000_A000);
        reg_wr(A_LEN, 32'h1);
        reg_rd(A_LEN, rd);               check("busy_len_kept", rd, 32'h8);
        reg_wr(A_CTRL, 32'h3);
        dev_access(1'b0, 32'h14, 32'h0, rd, er);
        check("bad_offset_err", er, 1);
        check("bad_offset_rdata", rd, 0);
        finish_transfer("busy", 8, 1);

        force_rsp_dly = 4;
        start_transfer(32'h0000_C000, 32'h0000_D000, 4, 1, -1, -1);
        cyc = 0;
        while (n_wr < 1 && cyc < 500) begin @(negedge clk); cyc++; end
        check("rst_reached_write", n_wr >= 1, 1);
        @(posedge clk); #1;
        rst_ni = 0; #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_ni = 1;
        force_rsp_dly = -1;
        exp_q.delete();
        mm = mem;
        @(negedge clk);
        reg_rd(A_STATUS, rd); check("midrst_status", rd, 0);
        reg_rd(A_SRC, rd);    check("midrst_src", rd, 0);
        start_transfer(32'h0000_C000, 32'h0000_D000, 4, 1, -1, -1);
        finish_transfer("after_rst", 4, 1);

        for (int it = 0; it < 20; it++) begin
            src    = $urandom;
            dst    = $urandom;
            len    = int'($urandom_range(0, 6));
            irq_en = 1'($urandom_range(0, 1));
            kind   = int'($urandom_range(0, 3));
            rerr   = (kind == 0 && len > 0) ? int'($urandom_range(0, len - 1)) : -1;
            werr   = (kind == 1 && len > 0) ? int'($urandom_range(0, len - 1)) : -1;
            start_transfer(src, dst, len, irq_en, rerr, werr);
            finish_transfer("rand", len, irq_en);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_dma_host.md
Name: bus_dma_host

Overview:
- Single-channel word-copy DMA engine that acts as a second initiator on the system bus.
- Software configures it through a small responder register port: the core writes registers through the bus device side.
- It then copies LEN 32-bit words from SRC to DST using the bus host-side req/gnt/rvalid protocol, with one outstanding transaction at a time.
- It signals completion through a level interrupt, routed to a fast irq input of the core.

Parameters:
- DataWidth, 32, data bus width; only 32 is supported.
- AddressWidth, 32, bus address width.
- LenWidth, 16, width of the word-count register.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- dev_req_i  in  1  register access request.
- dev_we_i  in  1  register write enable.
- dev_be_i  in  4  byte enables; ignored, all accesses are full-word.
- dev_addr_i  in  AddressWidth  register address; only bits [4:2] are decoded.
- dev_wdata_i  in  DataWidth  register write data.
- dev_rvalid_o  out  1  register response valid.
- dev_rdata_o  out  DataWidth  register read data.
- dev_err_o  out  1  unmapped register offset.
- host_req_o  out  1  bus request.
- host_gnt_i  in  1  bus grant.
- host_addr_o  out  AddressWidth  bus address; bits [1:0] are always 0.
- host_we_o  out  1  bus write.
- host_be_o  out  4  byte enables; always 4'hF.
- host_wdata_o  out  DataWidth  bus write data.
- host_rvalid_i  in  1  bus response valid.
- host_rdata_i  in  DataWidth  bus read data.
- host_err_i  in  1  bus error, qualified by host_rvalid_i.
- irq_o  out  1  interrupt, level.

Behaviour:
- Reset values:
  - All registers are 0.
  - dev_rvalid_o, dev_err_o, host_req_o, host_we_o and irq_o are 0.
  - dev_rdata_o, host_addr_o and host_wdata_o are 0.
  - host_be_o is 4'hF.
  - The FSM is in IDLE.
- Register map (offsets):
  - 0x00 SRC.
  - 0x04 DST.
  - 0x08 LEN (low LenWidth bits).
  - 0x0C CTRL: bit0 START (write-1 pulse, reads 0), bit1 IRQ_EN.
  - 0x10 STATUS: bit0 BUSY (read-only), bit1 DONE (W1C), bit2 ERR (W1C).
  - SRC and DST bits [1:0] are stored as 0.
- Device port:
  - dev_rvalid_o is asserted exactly 1 cycle after dev_req_i is sampled high.
  - dev_rdata_o is valid with dev_rvalid_o and is 0 on writes.
  - An offset >= 0x14 gives dev_err_o=1 with dev_rvalid_o, and has no side effect.
  - Writes to SRC, DST and LEN while BUSY=1 are ignored.
  - START while BUSY=1 is ignored.
  - IRQ_EN is always writable.
- START accepted with LEN=0: DONE=1 on the next cycle, BUSY stays 0, no bus traffic.
- START accepted with LEN>0:
  - Working copies are loaded: rd_ptr=SRC, wr_ptr=DST, remaining=LEN.
  - BUSY=1 and DONE=ERR=0.
- FSM (one outstanding transaction):
  - IDLE -> RD_REQ on START with LEN>0.
  - RD_REQ: host_req_o=1, host_we_o=0, host_addr_o=rd_ptr. Address and control are held stable until host_gnt_i; on grant -> RD_WAIT.
  - RD_WAIT: host_req_o=0. On host_rvalid_i:
    - If host_err_i -> ABORT.
    - Otherwise latch host_rdata_i into the data buffer, rd_ptr+=4, -> WR_REQ.
  - WR_REQ: host_req_o=1, host_we_o=1, host_addr_o=wr_ptr, host_wdata_o=buffer. Held until grant -> WR_WAIT.
  - WR_WAIT: on host_rvalid_i:
    - If host_err_i -> ABORT.
    - Otherwise wr_ptr+=4 and remaining-=1. If the new remaining is 0 -> IDLE with DONE=1 and BUSY=0; else -> RD_REQ.
  - ABORT (1 cycle): ERR=1, BUSY=0 -> IDLE. The failing word is not written or counted.
- Pointers wrap modulo 2^AddressWidth. There is no boundary checking.
- host_req_o never deasserts before grant.
- A rvalid arriving in a REQ state is treated as a protocol violation and is ignored; it is covered by an assertion.
- irq_o = IRQ_EN & (DONE | ERR), registered, so it rises 1 cycle after the flag sets.
- Simultaneous events:
  - A W1C of DONE in the same cycle hardware sets DONE: the set wins.
  - A START write combined with a W1C in the same word: the clear applies first, then the start.
- Reset mid-transfer returns immediately to the reset state. The in-flight bus response is dropped.

Decomposition:
- Package bus_dma_pkg holds:
  - the register offset constants (SRC, DST, LEN, CTRL, STATUS);
  - the CTRL/STATUS bit index constants;
  - the state enum dma_state_e {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, ABORT}.
- Sub-module bus_dma_regs contains the device-port decode, register file, W1C logic and irq register. It exports the config values and a start pulse, and imports the done/err set pulses and BUSY.
- The top contains the transfer FSM and pointers.

Test Plan:
- Copy 4 words:
  - Setup: SRC=0x100000, DST=0x100100, LEN=4, IRQ_EN=1, START.
  - Response: 8 bus transactions alternating read/write at 0x100000/0x100100 … 0x10000C/0x10010C.
  - Destination memory matches source, STATUS=0x2, irq_o=1; W1C DONE gives irq_o=0.
- LEN=0 START: no host_req_o; STATUS reads 0x2 one cycle later.
- Delayed grant: host_gnt_i held low for 3 cycles on the 1st read -> host_req_o, host_addr_o and host_we_o are stable throughout; the copy completes correctly.
- Bus error on the 2nd read (LEN=3): exactly 1 destination write occurs; STATUS=0x4; irq_o=1 if IRQ_EN.
- Access rules while BUSY=1: write SRC=0xDEAD0000 -> SRC readback is unchanged. A read at offset 0x14 -> dev_err_o=1 with dev_rvalid_o.
- Reset mid-transfer: assert rst_ni=0 during WR_WAIT -> all outputs return to reset values the same cycle, STATUS=0, and a new transfer completes normally.
